// File: rtl/prio_event_queue.sv
// Change detector on the priority-encoder winner index, feeding a small FIFO
// of events handed out over valid/ready, with a sticky overflow flag and an accept counter.
module prio_event_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               idx_in,
  input  logic                     any_in,
  input  logic                     evt_ready,
  input  logic                     clr_ovf,
  output logic                     evt_valid,
  output logic [1:0]               evt_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [2:0]    prev;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic evt_det;
  logic pop;
  logic push;
  logic drop;

  // Status flags come from level only, so there is no input-to-flag path.
  assign empty     = (level == '0);
  assign full      = (level == FULL_LVL);
  assign evt_valid = !empty;
  assign evt_data  = evt_valid ? mem[rd_ptr] : 2'b00;

  always_comb begin
    evt_det = any_in && ({any_in, idx_in} != prev);
    pop     = evt_valid && evt_ready;
    push    = evt_det && (!full || pop);
    drop    = evt_det && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 3'b000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      prev <= {any_in, idx_in};
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      // A drop on the same edge as a clear wins, so no loss goes unreported.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage is not reset; empty masks evt_data and level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= idx_in;
  end

endmodule

// File: tb/tb_prio_event_queue.sv
// Directed bench for prio_event_queue: a vector table of per-edge stimulus and
// expected outputs, plus hand-written sequences for reset and counter wrap.
module tb_prio_event_queue;

  logic       clk;
  logic       rst_n;
  logic [1:0] idx_in;
  logic       any_in;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [1:0] evt_data;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  prio_event_queue #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx_in    (idx_in),
    .any_in    (any_in),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       any;
    logic [1:0] idx;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] d;
    logic [2:0] l;
    logic       f;
    logic       e;
    logic       o;
    logic [7:0] c;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] d,
                         input logic [2:0] l, input logic f, input logic e,
                         input logic o, input logic [7:0] c);
    chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(v));
    chk({tag, ".evt_data"},  32'(evt_data),  32'(d));
    chk({tag, ".level"},     32'(level),     32'(l));
    chk({tag, ".full"},      32'(full),      32'(f));
    chk({tag, ".empty"},     32'(empty),     32'(e));
    chk({tag, ".overflow"},  32'(overflow),  32'(o));
    chk({tag, ".count"},     32'(count),     32'(c));
  endtask

  task automatic drive(input logic a, input logic [1:0] i, input logic r, input logic c);
    any_in    = a;
    idx_in    = i;
    evt_ready = r;
    clr_ovf   = c;
  endtask

  initial begin
    //          any idx   rdy clr | v  d     l     f  e  o  count
    // single event held three cycles, then popped; ready while empty
    vt[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[1]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd1};
    // drop and re-raise of the same index gives two events
    vt[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd2};
    vt[6]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd2};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3};
    // idx change with any_in low is not an event; drain
    vt[8]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3};
    vt[9]  = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd3};
    vt[10] = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd3};
    // five changes into a depth-4 queue: last one dropped
    vt[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd4};
    vt[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd5};
    vt[13] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 1'b0, 8'd6};
    vt[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 8'd7};
    vt[15] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, 1'b1, 1'b0, 1'b1, 8'd7};
    // push and pop while full
    vt[16] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd8};
    // clear with simultaneous drop keeps flag; clear alone drops it
    vt[17] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1, 3'd4, 1'b1, 1'b0, 1'b1, 8'd8};
    vt[18] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1, 3'd4, 1'b1, 1'b0, 1'b0, 8'd8};
    // drain: order 1,2,3,1
    vt[19] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 2'd2, 3'd3, 1'b0, 1'b0, 1'b0, 8'd8};
    vt[20] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0, 1'b0, 8'd8};
    vt[21] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd8};
    vt[22] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd8};

    rst_n = 1'b0;
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset with any_in=1 is an event (vt[0])
    for (int i = 0; i < 23; i++) begin
      drive(vt[i].any, vt[i].idx, vt[i].rdy, vt[i].clr);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].v, vt[i].d, vt[i].l, vt[i].f, vt[i].e, vt[i].o, vt[i].c);
    end

    // build level 3, then pulse reset between edges
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("prefill", 1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 1'b0, 8'd11);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst_evt", 1'b1, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);

    // 255 more accepted pushes with concurrent pops: count wraps to 0
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    chk_all("cnt_wrap", 1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prio_event_queue.md
PRIO_EVENT_QUEUE -- requirements
Module: prio_event_queue

Purpose: downstream stage of the 4-to-2 priority encoder. Detects changes in the encoded winner index, queues them as events, and hands them out over a valid/ready interface.

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the accepted-event counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- idx_in, in, 2, encoded index from the priority encoder.
- any_in, in, 1, high when at least one encoder request is active.
- evt_ready, in, 1, consumer accepts the head entry.
- clr_ovf, in, 1, clears the sticky overflow flag.
- evt_valid, out, 1, head entry is present.
- evt_data, out, 2, index held in the head entry.
- level, out, log2(DEPTH)+1, current occupancy.
- full, out, 1, level equals DEPTH.
- empty, out, 1, level equals 0.
- overflow, out, 1, sticky flag: an event was dropped.
- count, out, CNT_W, number of events accepted into the FIFO.

REQ-003 The block SHALL use one clock only, and rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL hold a previous-sample register prev = {any, idx}, loaded from {any_in, idx_in} on every clock edge.

REQ-005 An event SHALL be detected combinationally when any_in = 1 and {any_in, idx_in} != prev.

REQ-006 No event SHALL be detected while any_in = 0, whatever the value of idx_in.

REQ-007 Push: a detected event SHALL write idx_in into the tail entry at the same edge that updates prev, provided the FIFO is not full or a pop occurs on that edge.

REQ-008 Latency: an event pushed into an empty FIFO SHALL give evt_valid = 1 with evt_data = idx_in immediately after that edge (one cycle from input to output).

REQ-009 Pop: the head entry SHALL be removed on an edge where evt_valid and evt_ready are both 1.

REQ-010 evt_ready SHALL be ignored while the FIFO is empty.

REQ-011 evt_data SHALL stay stable while evt_valid = 1 and evt_ready = 0.

REQ-012 evt_data SHALL read 2'b00 while the FIFO is empty.

REQ-013 Simultaneous push and pop SHALL both take effect and leave level unchanged. This holds when the FIFO is full.

REQ-014 A push while full with no pop SHALL drop the event, leave the FIFO contents and count unchanged, and set overflow.

REQ-015 overflow SHALL stay set until clr_ovf = 1. If clr_ovf and a new drop occur on the same edge, the set SHALL take priority.

REQ-016 count SHALL increment by 1 for each accepted push and SHALL wrap modulo 2^CNT_W.

REQ-017 The read and write pointers SHALL wrap modulo DEPTH. level SHALL be kept consistent with the pointers at all times.

REQ-018 full, empty and evt_valid SHALL be derived from registered state only, with no combinational path from the inputs.

REQ-019 Entries SHALL be delivered in push order (FIFO), with no reordering and no duplication.

Reset
REQ-020 While rst_n = 0, the block SHALL force:
- prev = 3'b000;
- FIFO pointers and level = 0;
- evt_valid = 0, evt_data = 0, empty = 1, full = 0;
- overflow = 0, count = 0.

REQ-021 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.

REQ-022 After rst_n deasserts, any_in = 1 on the first edge SHALL be treated as an event, because prev has any = 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single event: reset; any_in=1, idx_in=2'b11 for 3 cycles, evt_ready=0 -> exactly one entry; evt_data=3, level=1, count=1.
- Drop and re-raise: any_in=1 idx=1; then any_in=0 one cycle; then any_in=1 idx=1 -> two entries, both idx 1, count=2.
- Overflow: DEPTH=4, evt_ready=0, 5 distinct index changes -> full=1, level=4, overflow=1, count=4; head is the first index pushed.
- Push and pop while full: full FIFO, evt_ready=1, and an index change on the same edge -> level stays 4, order preserved, count increments, overflow unchanged.
- Clear overflow: clr_ovf=1 on an edge with a simultaneous drop -> overflow stays 1; clr_ovf=1 with no drop on the next edge -> overflow=0.
- Reset mid-run: rst_n pulsed low between edges with level=3 -> level=0, empty=1, evt_valid=0, count=0 immediately.
